// File: rtl/jenc_rgb2ycbcr.sv
// rtl/jenc_rgb2ycbcr.sv - RGB to JFIF YCbCr 3-stage stall-all pipeline with frame/line markers
// Build option: define JENC_RGB2YCBCR_CHROMA422_EN for horizontal 4:2:2 chroma averaging.

module jenc_rgb2ycbcr #(
   parameter int DW            = 8,
   parameter int SENSOR_X_SIZE = 720,
   parameter int SENSOR_Y_SIZE = 720,
   localparam int XW           = $clog2(SENSOR_X_SIZE),
   localparam int YW           = $clog2(SENSOR_Y_SIZE)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [2:0][DW-1:0]   rgb24,
   input  logic                 rgb24_valid,
   output logic                 rgb24_hold,
   input  logic                 frame_valid,
   input  logic                 line_valid,
   output logic [2:0][DW-1:0]   yuv,
   output logic                 yuv_valid,
   output logic                 yuv_c_valid,
   output logic                 yuv_sof,
   output logic                 yuv_eol,
   output logic                 yuv_eof,
   input  logic                 yuv_hold,
   output logic                 geom_err,
   input  logic [XW-1:0]        x_size_m1,
   input  logic [YW-1:0]        y_size_m1
);

   // Coefficients x256, row-major: Y(R,G,B), Cb(R,G,B), Cr(R,G,B)
   localparam logic signed [16:0] COEF [0:8] = '{
      17'sd77,  17'sd150,  17'sd29,
     -17'sd43, -17'sd85,   17'sd128,
      17'sd128, -17'sd107, -17'sd21
   };
   localparam logic [XW-1:0] X_ONE = 1;
   localparam logic [YW-1:0] Y_ONE = 1;

   logic acc;
   logic at_sof, at_eol, at_eof, err_det;

   logic [XW-1:0] x_cnt_q;
   logic [YW-1:0] y_cnt_q;
   logic          fv_q, lv_q, geom_err_q;

   logic signed [16:0] p_d [0:8];
   logic signed [16:0] p_q [0:8];
   logic               v1_q, sof1_q, eol1_q, eof1_q;

   logic signed [18:0] s_d [0:2];
   logic signed [18:0] s_q [0:2];
   logic               v2_q, sof2_q, eol2_q, eof2_q;

   logic [DW-1:0]      y_n, cb_n, cr_n;

   logic [2:0][DW-1:0] yuv_q;
   logic               yuv_valid_q, yuv_c_valid_q;
   logic               yuv_sof_q, yuv_eol_q, yuv_eof_q;

`ifdef JENC_RGB2YCBCR_CHROMA422_EN
   logic               odd1_q, odd2_q;
   logic [DW-1:0]      cb_even_q, cr_even_q;
   logic [DW:0]        cb_sum, cr_sum;
`endif

   // Signed 19-bit value to unsigned component range
   function automatic logic [DW-1:0] clamp_u8(input logic signed [18:0] v);
      if (v < 19'sd0)
         return '0;
      else if (v > 19'sd255)
         return {DW{1'b1}};
      else
         return v[DW-1:0];
   endfunction

   assign rgb24_hold = yuv_hold;
   assign acc        = rgb24_valid & line_valid & ~yuv_hold;

   // Geometry decode of the current counter position and error detection
   always_comb begin
      at_sof  = (x_cnt_q == '0) && (y_cnt_q == '0);
      at_eol  = (x_cnt_q == x_size_m1);
      at_eof  = at_eol && (y_cnt_q == y_size_m1);
      err_det = (fv_q & ~frame_valid & ~at_sof) |
                (lv_q & ~line_valid & (x_cnt_q != '0));
`ifdef JENC_RGB2YCBCR_CHROMA422_EN
      // Chroma pairing needs an even pixel count per line
      err_det = err_det | (acc & at_eol & ~x_size_m1[0]);
`endif
   end

   // Position counters; a geometry error overrides any wrap in the same cycle
   always_ff @(posedge clk) begin
      if (!resetn) begin
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
         fv_q       <= 1'b0;
         lv_q       <= 1'b0;
         geom_err_q <= 1'b0;
      end else begin
         fv_q       <= frame_valid;
         lv_q       <= line_valid;
         geom_err_q <= err_det;
         if (err_det) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
         end else if (acc) begin
            if (at_eol) begin
               x_cnt_q <= '0;
               y_cnt_q <= at_eof ? '0 : y_cnt_q + Y_ONE;
            end else begin
               x_cnt_q <= x_cnt_q + X_ONE;
            end
         end
      end
   end

   // Nine coefficient products from the incoming pixel
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         for (int j = 0; j < 3; j++) begin
            p_d[3*c+j] = COEF[3*c+j] * $signed({{(17-DW){1'b0}}, rgb24[j]});
         end
      end
   end

   // Stage 1: products with their pixel's valid and markers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 9; i++) p_q[i] <= '0;
         v1_q   <= 1'b0;
         sof1_q <= 1'b0;
         eol1_q <= 1'b0;
         eof1_q <= 1'b0;
`ifdef JENC_RGB2YCBCR_CHROMA422_EN
         odd1_q <= 1'b0;
`endif
      end else if (!yuv_hold) begin
         for (int i = 0; i < 9; i++) p_q[i] <= p_d[i];
         v1_q   <= acc;
         sof1_q <= acc & at_sof;
         eol1_q <= acc & at_eol;
         eof1_q <= acc & at_eof;
`ifdef JENC_RGB2YCBCR_CHROMA422_EN
         odd1_q <= x_cnt_q[0];
`endif
      end
   end

   // Per-component sums with the rounding constant
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         s_d[c] = p_q[3*c] + p_q[3*c+1] + p_q[3*c+2] + 19'sd128;
      end
   end

   // Stage 2: rounded sums
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int c = 0; c < 3; c++) s_q[c] <= '0;
         v2_q   <= 1'b0;
         sof2_q <= 1'b0;
         eol2_q <= 1'b0;
         eof2_q <= 1'b0;
`ifdef JENC_RGB2YCBCR_CHROMA422_EN
         odd2_q <= 1'b0;
`endif
      end else if (!yuv_hold) begin
         for (int c = 0; c < 3; c++) s_q[c] <= s_d[c];
         v2_q   <= v1_q;
         sof2_q <= sof1_q;
         eol2_q <= eol1_q;
         eof2_q <= eof1_q;
`ifdef JENC_RGB2YCBCR_CHROMA422_EN
         odd2_q <= odd1_q;
`endif
      end
   end

   // Floor shift, chroma offset and clamp
   always_comb begin
      y_n  = clamp_u8(s_q[0] >>> 8);
      cb_n = clamp_u8((s_q[1] >>> 8) + 19'sd128);
      cr_n = clamp_u8((s_q[2] >>> 8) + 19'sd128);
`ifdef JENC_RGB2YCBCR_CHROMA422_EN
      cb_sum = {1'b0, cb_even_q} + {1'b0, cb_n} + {{DW{1'b0}}, 1'b1};
      cr_sum = {1'b0, cr_even_q} + {1'b0, cr_n} + {{DW{1'b0}}, 1'b1};
`endif
   end

   // Stage 3: registered outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         yuv_q         <= '0;
         yuv_valid_q   <= 1'b0;
         yuv_c_valid_q <= 1'b0;
         yuv_sof_q     <= 1'b0;
         yuv_eol_q     <= 1'b0;
         yuv_eof_q     <= 1'b0;
`ifdef JENC_RGB2YCBCR_CHROMA422_EN
         cb_even_q     <= '0;
         cr_even_q     <= '0;
`endif
      end else if (!yuv_hold) begin
         yuv_q[0]    <= y_n;
         yuv_valid_q <= v2_q;
         yuv_sof_q   <= sof2_q;
         yuv_eol_q   <= eol2_q;
         yuv_eof_q   <= eof2_q;
`ifdef JENC_RGB2YCBCR_CHROMA422_EN
         // Even pixel stashes its chroma; odd pixel emits the pair average
         yuv_c_valid_q <= v2_q & odd2_q;
         if (v2_q && !odd2_q) begin
            cb_even_q <= cb_n;
            cr_even_q <= cr_n;
         end
         if (v2_q && odd2_q) begin
            yuv_q[1] <= cb_sum[DW:1];
            yuv_q[2] <= cr_sum[DW:1];
         end
`else
         yuv_q[1]      <= cb_n;
         yuv_q[2]      <= cr_n;
         yuv_c_valid_q <= v2_q;
`endif
      end
   end

   assign yuv         = yuv_q;
   assign yuv_valid   = yuv_valid_q;
   assign yuv_c_valid = yuv_c_valid_q;
   assign yuv_sof     = yuv_sof_q;
   assign yuv_eol     = yuv_eol_q;
   assign yuv_eof     = yuv_eof_q;
   assign geom_err    = geom_err_q;

endmodule

// File: tb/tb_jenc_rgb2ycbcr.sv
// tb/tb_jenc_rgb2ycbcr.sv - self-checking bench for jenc_rgb2ycbcr (4:4:4 build)

module tb_jenc_rgb2ycbcr;

   localparam int DW = 8;
   localparam int XW = $clog2(720);
   localparam int YW = $clog2(720);

   logic                clk = 1'b0;
   logic                resetn;
   logic [2:0][DW-1:0]  rgb24;
   logic                rgb24_valid;
   logic                rgb24_hold;
   logic                frame_valid;
   logic                line_valid;
   logic [2:0][DW-1:0]  yuv;
   logic                yuv_valid;
   logic                yuv_c_valid;
   logic                yuv_sof;
   logic                yuv_eol;
   logic                yuv_eof;
   logic                yuv_hold;
   logic                geom_err;
   logic [XW-1:0]       x_size_m1;
   logic [YW-1:0]       y_size_m1;

   always #5 clk = ~clk;

   jenc_rgb2ycbcr #(.DW(DW), .SENSOR_X_SIZE(720), .SENSOR_Y_SIZE(720)) dut (
      .clk(clk), .resetn(resetn),
      .rgb24(rgb24), .rgb24_valid(rgb24_valid), .rgb24_hold(rgb24_hold),
      .frame_valid(frame_valid), .line_valid(line_valid),
      .yuv(yuv), .yuv_valid(yuv_valid), .yuv_c_valid(yuv_c_valid),
      .yuv_sof(yuv_sof), .yuv_eol(yuv_eol), .yuv_eof(yuv_eof),
      .yuv_hold(yuv_hold), .geom_err(geom_err),
      .x_size_m1(x_size_m1), .y_size_m1(y_size_m1)
   );

   typedef struct packed {
      logic [7:0] y;
      logic [7:0] cb;
      logic [7:0] cr;
      logic       cv;
      logic       sof;
      logic       eol;
      logic       eof;
   } pix_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   pr [0:63];
   int   pg [0:63];
   int   pb [0:63];

   pix_t obs_q [$];
   int   obs_cyc [$];
   int   err_seen = 0;
   int   stab_viol = 0;
   int   mirror_viol = 0;
   logic [30:0] snap, snap_prev = '0;
   logic hold_prev = 1'b0;
   logic rst_prev = 1'b0;

   always @(posedge clk) cyc++;

   // Monitor: collects accepted output beats and hold/mirror/error observations
   always @(negedge clk) begin
      snap = {yuv, yuv_valid, yuv_c_valid, yuv_sof, yuv_eol, yuv_eof, geom_err};
      if (resetn) begin
         if (rst_prev && hold_prev && (snap[30:1] !== snap_prev[30:1])) stab_viol++;
         if (rgb24_hold !== yuv_hold) mirror_viol++;
         if (geom_err) err_seen++;
         if (yuv_valid && !yuv_hold) begin
            obs_q.push_back({yuv[0], yuv[1], yuv[2], yuv_c_valid, yuv_sof, yuv_eol, yuv_eof});
            obs_cyc.push_back(cyc);
         end
      end
      snap_prev = snap;
      hold_prev = yuv_hold;
      rst_prev  = resetn;
   end

   // Reference model: JFIF conversion with floor division and clamping
   function automatic int fl256(input int v);
      return (v + 65536) / 256 - 256;
   endfunction

   function automatic int clip(input int v);
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   function automatic pix_t model(input int idx, input int pos, input int nx, input int ny);
      pix_t m;
      int r, g, b, n;
      r = pr[idx]; g = pg[idx]; b = pb[idx]; n = nx * ny;
      m.y   = 8'(clip(fl256(77*r + 150*g + 29*b + 128)));
      m.cb  = 8'(clip(fl256(-43*r - 85*g + 128*b + 128) + 128));
      m.cr  = 8'(clip(fl256(128*r - 107*g - 21*b + 128) + 128));
      m.cv  = 1'b1;
      m.sof = ((pos % n) == 0);
      m.eol = ((pos % nx) == nx - 1);
      m.eof = ((pos % n) == n - 1);
      return m;
   endfunction

   task automatic load_random(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         pr[i] = int'($urandom_range(255));
         pg[i] = int'($urandom_range(255));
         pb[i] = int'($urandom_range(255));
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0; rgb24_valid = 1'b0; line_valid = 1'b0; frame_valid = 1'b0;
      yuv_hold = 1'b0; rgb24 = '0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   // Streams pixels first..first+n-1, with random downstream hold at pct percent
   task automatic drive(input int first, input int n, input int pct, input bit drain);
      int k;
      k = first;
      frame_valid = 1'b1;
      line_valid  = 1'b1;
      while (k < first + n) begin
         yuv_hold    = (int'($urandom_range(99)) < pct);
         rgb24[0]    = 8'(pr[k]);
         rgb24[1]    = 8'(pg[k]);
         rgb24[2]    = 8'(pb[k]);
         rgb24_valid = 1'b1;
         @(posedge clk); #1;
         if (!yuv_hold) k++;
      end
      rgb24_valid = 1'b0;
      yuv_hold    = 1'b0;
      if (drain) begin
         repeat (6) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      int base;
      resetn = 1'b0; rgb24_valid = 1'b1; line_valid = 1'b1; frame_valid = 1'b1;
      yuv_hold = 1'b0; rgb24 = {8'd255, 8'd255, 8'd255};
      x_size_m1 = 10'd3; y_size_m1 = 10'd1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({yuv_valid, yuv_c_valid} !== 2'b00) begin
         errors++; $display("FAIL reset_valid: got %b want 00", {yuv_valid, yuv_c_valid});
      end
      checks++;
      if (yuv !== '0) begin
         errors++; $display("FAIL reset_yuv: got %h want 000000", yuv);
      end
      checks++;
      if ({yuv_sof, yuv_eol, yuv_eof, geom_err} !== 4'b0000) begin
         errors++; $display("FAIL reset_markers: got %b want 0000", {yuv_sof, yuv_eol, yuv_eof, geom_err});
      end
      // Reset in mid-frame discards in-flight pixels and restarts at sof
      do_reset();
      load_random(0, 3);
      drive(0, 2, 0, 1'b0);
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      base = obs_q.size();
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (obs_q.size() != base) begin
         errors++; $display("FAIL reset_discard: got %0d beats want 0", obs_q.size() - base);
      end
      drive(2, 1, 0, 1'b1);
      checks++;
      if (obs_q.size() != base + 1) begin
         errors++; $display("FAIL reset_restart_count: got %0d beats want 1", obs_q.size() - base);
      end else if (obs_q[base] !== model(2, 0, 4, 2)) begin
         errors++; $display("FAIL reset_restart_sof: got %h want %h", obs_q[base], model(2, 0, 4, 2));
      end
   endtask

   task automatic test_latency();
      int lat;
      do_reset();
      x_size_m1 = 10'd0; y_size_m1 = 10'd0;
      frame_valid = 1'b1; line_valid = 1'b1;
      rgb24 = {8'd255, 8'd255, 8'd255}; rgb24_valid = 1'b1;
      @(posedge clk); #1 rgb24_valid = 1'b0;
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (yuv_valid) begin
            lat = i + 1;
            break;
         end
      end
      checks++;
      if (lat != 3) begin
         errors++; $display("FAIL latency: got %0d cycles want 3", lat);
      end
      checks++;
      if ({yuv[0], yuv[1], yuv[2]} !== {8'd255, 8'd128, 8'd128}) begin
         errors++; $display("FAIL white: got %0d,%0d,%0d want 255,128,128", yuv[0], yuv[1], yuv[2]);
      end
      checks++;
      if ({yuv_sof, yuv_eol, yuv_eof, yuv_c_valid} !== 4'b1111) begin
         errors++; $display("FAIL single_pixel_markers: got %b want 1111", {yuv_sof, yuv_eol, yuv_eof, yuv_c_valid});
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_colors();
      int base;
      do_reset();
      x_size_m1 = 10'd0; y_size_m1 = 10'd0;
      pr[0] = 255; pg[0] = 0;   pb[0] = 0;
      pr[1] = 0;   pg[1] = 0;   pb[1] = 255;
      pr[2] = 0;   pg[2] = 0;   pb[2] = 0;
      pr[3] = 255; pg[3] = 255; pb[3] = 255;
      load_random(4, 12);
      base = obs_q.size();
      drive(0, 16, 0, 1'b1);
      checks++;
      if (obs_q.size() != base + 16) begin
         errors++; $display("FAIL colors_count: got %0d want 16", obs_q.size() - base);
      end else begin
         checks++;
         if ({obs_q[base].y, obs_q[base].cb, obs_q[base].cr} !== {8'd77, 8'd85, 8'd255}) begin
            errors++; $display("FAIL red: got %h want 4d55ff", {obs_q[base].y, obs_q[base].cb, obs_q[base].cr});
         end
         checks++;
         if ({obs_q[base+1].y, obs_q[base+1].cb, obs_q[base+1].cr} !== {8'd29, 8'd255, 8'd107}) begin
            errors++; $display("FAIL blue: got %h want 1dff6b", {obs_q[base+1].y, obs_q[base+1].cb, obs_q[base+1].cr});
         end
         checks++;
         if ({obs_q[base+2].y, obs_q[base+2].cb, obs_q[base+2].cr} !== {8'd0, 8'd128, 8'd128}) begin
            errors++; $display("FAIL black: got %h want 008080", {obs_q[base+2].y, obs_q[base+2].cb, obs_q[base+2].cr});
         end
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (obs_q[base+k] !== model(k, k, 1, 1)) begin
               errors++; $display("FAIL colors pix%0d: got %h want %h", k, obs_q[base+k], model(k, k, 1, 1));
            end
         end
      end
   endtask

   task automatic test_frame();
      int base, e0;
      do_reset();
      x_size_m1 = 10'd3; y_size_m1 = 10'd1;
      load_random(0, 8);
      base = obs_q.size();
      e0 = err_seen;
      drive(0, 8, 0, 1'b1);
      checks++;
      if (obs_q.size() != base + 8) begin
         errors++; $display("FAIL frame_count: got %0d want 8", obs_q.size() - base);
      end else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_q[base+k] !== model(k, k, 4, 2)) begin
               errors++; $display("FAIL frame pix%0d: got %h want %h", k, obs_q[base+k], model(k, k, 4, 2));
            end
         end
         checks++;
         if (obs_cyc[base+7] - obs_cyc[base] != 7) begin
            errors++; $display("FAIL frame_contiguous: got span %0d want 7", obs_cyc[base+7] - obs_cyc[base]);
         end
      end
      checks++;
      if (err_seen != e0) begin
         errors++; $display("FAIL frame_no_geom_err: got %0d pulses want 0", err_seen - e0);
      end
   endtask

   task automatic test_random_hold();
      int base, s0, m0;
      do_reset();
      x_size_m1 = 10'd3; y_size_m1 = 10'd1;
      load_random(0, 16);
      base = obs_q.size();
      s0 = stab_viol; m0 = mirror_viol;
      drive(0, 16, 50, 1'b1);
      checks++;
      if (obs_q.size() != base + 16) begin
         errors++; $display("FAIL hold_count: got %0d want 16", obs_q.size() - base);
      end else begin
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (obs_q[base+k] !== model(k, k, 4, 2)) begin
               errors++; $display("FAIL hold pix%0d: got %h want %h", k, obs_q[base+k], model(k, k, 4, 2));
            end
         end
      end
      checks++;
      if (stab_viol != s0) begin
         errors++; $display("FAIL hold_stable: got %0d changes while held want 0", stab_viol - s0);
      end
      checks++;
      if (mirror_viol != m0) begin
         errors++; $display("FAIL hold_mirror: got %0d mismatches want 0", mirror_viol - m0);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      do_reset();
      x_size_m1 = 10'd4; y_size_m1 = 10'd2;
      load_random(0, 30);
      base = obs_q.size();
      drive(0, 30, 20, 1'b1);
      checks++;
      if (obs_q.size() != base + 30) begin
         errors++; $display("FAIL b2b_count: got %0d want 30", obs_q.size() - base);
      end else begin
         for (int k = 0; k < 30; k++) begin
            checks++;
            if (obs_q[base+k] !== model(k, k, 5, 3)) begin
               errors++; $display("FAIL b2b pix%0d: got %h want %h", k, obs_q[base+k], model(k, k, 5, 3));
            end
         end
      end
   endtask

   task automatic test_geom_err();
      int base, e0;
      int pos [0:5];
      pos = '{0, 1, 0, 1, 2, 3};
      do_reset();
      x_size_m1 = 10'd3; y_size_m1 = 10'd1;
      load_random(0, 6);
      base = obs_q.size();
      drive(0, 2, 0, 1'b0);
      e0 = err_seen;
      line_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (err_seen - e0 != 1) begin
         errors++; $display("FAIL geom_line_pulse: got %0d cycles want 1", err_seen - e0);
      end
      drive(2, 4, 0, 1'b1);
      checks++;
      if (obs_q.size() != base + 6) begin
         errors++; $display("FAIL geom_count: got %0d want 6", obs_q.size() - base);
      end else begin
         for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs_q[base+k] !== model(k, pos[k], 4, 2)) begin
               errors++; $display("FAIL geom pix%0d: got %h want %h", k, obs_q[base+k], model(k, pos[k], 4, 2));
            end
         end
      end
      // Counters now sit at line 1: dropping frame_valid is a short frame
      e0 = err_seen;
      line_valid = 1'b0;
      frame_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (err_seen - e0 != 1) begin
         errors++; $display("FAIL geom_frame_pulse: got %0d cycles want 1", err_seen - e0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; rgb24_valid = 1'b0; line_valid = 1'b0; frame_valid = 1'b0;
      yuv_hold = 1'b0; rgb24 = '0; x_size_m1 = '0; y_size_m1 = '0;
      test_reset();
      test_latency();
      test_colors();
      test_frame();
      test_random_hold();
      test_back_to_back();
      test_geom_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
